// File: rtl/ucsbece154b_fifo_writer_if.sv
// Handshake bundle between ucsbece154b_fifo_writer and its memory port, FIFO and control.
// master = the writer engine, slave = the surrounding system.
interface ucsbece154b_fifo_writer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  start_i;
    logic [ADDR_WIDTH-1:0] base_addr_i;
    logic                  stop_i;
    logic                  redirect_i;
    logic [ADDR_WIDTH-1:0] redirect_addr_i;
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  fifo_push_o;
    logic [DATA_WIDTH-1:0] fifo_data_o;
    logic                  fifo_full_i;
    logic                  fifo_pop_i;
    logic                  busy_o;
    logic                  overflow_o;

    modport master (
        input  start_i, base_addr_i, stop_i, redirect_i, redirect_addr_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, fifo_full_i, fifo_pop_i,
        output mem_req_o, mem_addr_o, fifo_push_o, fifo_data_o, busy_o, overflow_o
    );

    modport slave (
        output start_i, base_addr_i, stop_i, redirect_i, redirect_addr_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, fifo_full_i, fifo_pop_i,
        input  mem_req_o, mem_addr_o, fifo_push_o, fifo_data_o, busy_o, overflow_o
    );
endinterface

// File: rtl/ucsbece154b_fifo_writer.sv
// Write-side engine for ucsbece154b_fifo: streams sequential memory reads into the FIFO under
// credit control. Define UCSBECE154B_FIFO_WRITER_PERF_EN to add push/stall counters.
module ucsbece154b_fifo_writer #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int NR_ENTRIES      = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_STRIDE     = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    ucsbece154b_fifo_writer_if.master bus
`ifdef UCSBECE154B_FIFO_WRITER_PERF_EN
    ,
    output logic [31:0] push_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);
    localparam int CW = $clog2(NR_ENTRIES) + 1;
    localparam logic [CW-1:0]         ONE    = CW'(1);
    localparam logic [31:0]           NR_U   = 32'(NR_ENTRIES);
    localparam logic [31:0]           MAX_U  = 32'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         occ_q, occ_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic                  mem_req_q, mem_req_d;
    logic                  busy_q, busy_d;
    logic                  overflow_q, overflow_d;
    logic                  granted, rsp_valid, push, pop_eff;
    logic [DATA_WIDTH-1:0] rdata;

    // Responses with nothing in flight are stray (e.g. after reset) and are ignored.
    assign granted   = mem_req_q & bus.mem_gnt_i;
    assign rsp_valid = bus.mem_rvalid_i & (outst_q != '0);
    assign push      = rsp_valid & (drop_q == '0);
    assign pop_eff   = bus.fifo_pop_i & ((occ_q != '0) | push);
    assign rdata     = bus.mem_rdata_i;

    always_comb begin
        outst_d = outst_q;
        if (granted && !rsp_valid)      outst_d = outst_q + ONE;
        else if (!granted && rsp_valid) outst_d = outst_q - ONE;

        occ_d = occ_q;
        if (push && !pop_eff)      occ_d = occ_q + ONE;
        else if (!push && pop_eff) occ_d = occ_q - ONE;

        drop_d = drop_q;
        if (rsp_valid && (drop_q != '0)) drop_d = drop_q - ONE;

        addr_d  = granted ? addr_q + STRIDE : addr_q;
        state_d = state_q;

        // A redirect discards everything still in flight, including a grant taken this cycle.
        if (bus.redirect_i) begin
            state_d = (outst_d == '0) ? FETCH : DRAIN;
            addr_d  = bus.redirect_addr_i;
            drop_d  = outst_d;
            occ_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        state_d = FETCH;
                        addr_d  = bus.base_addr_i;
                    end
                end
                FETCH:   if (bus.stop_i) state_d = IDLE;
                DRAIN:   if (drop_d == '0) state_d = FETCH;
                default: state_d = IDLE;
            endcase
        end

        mem_req_d  = (state_d == FETCH) &&
                     ((32'(occ_d) + 32'(outst_d)) < NR_U) &&
                     (32'(outst_d) < MAX_U);
        busy_d     = (state_d != IDLE) || (outst_d != '0);
        overflow_d = overflow_q | (push & bus.fifo_full_i & ~bus.fifo_pop_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            occ_q      <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            occ_q      <= occ_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            mem_req_q  <= mem_req_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.fifo_push_o = push;
    assign bus.fifo_data_o = rdata;
    assign bus.busy_o      = busy_q;
    assign bus.overflow_o  = overflow_q;

`ifdef UCSBECE154B_FIFO_WRITER_PERF_EN
    logic [31:0] push_cnt_q, stall_cnt_q;

    // In FETCH the request is low only when credit is exhausted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            push_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else if (bus.start_i) begin
            push_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push) push_cnt_q <= push_cnt_q + 32'd1;
            if ((state_q == FETCH) && !mem_req_q) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign push_cnt_o  = push_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_ucsbece154b_fifo_writer.sv
// Directed bench for ucsbece154b_fifo_writer: a per-cycle vector table for streaming and credit
// return, plus hand sequences for redirect, address wrap/stop and asynchronous reset.
`timescale 1ns/1ps
module tb_ucsbece154b_fifo_writer;
    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    ucsbece154b_fifo_writer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

`ifdef UCSBECE154B_FIFO_WRITER_PERF_EN
    logic [31:0] push_cnt, stall_cnt;
`endif

    ucsbece154b_fifo_writer #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NR_ENTRIES(4), .MAX_OUTSTANDING(2), .ADDR_STRIDE(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
`ifdef UCSBECE154B_FIFO_WRITER_PERF_EN
        ,
        .push_cnt_o(push_cnt),
        .stall_cnt_o(stall_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        start;
        logic [31:0] base;
        logic        stop;
        logic        gnt;
        logic        rvalid;
        logic        full;
        logic        pop;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_push;
        logic        e_busy;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic st, input logic [31:0] b, input logic sp,
                                input logic g, input logic rv, input logic fl, input logic pp,
                                input logic er, input logic [31:0] ea, input logic ep,
                                input logic eb);
        vec_t v;
        v.start = st; v.base = b; v.stop = sp; v.gnt = g; v.rvalid = rv; v.full = fl;
        v.pop = pp; v.e_req = er; v.e_addr = ea; v.e_push = ep; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.start_i = 0; bus.base_addr_i = '0; bus.stop_i = 0; bus.redirect_i = 0;
        bus.redirect_addr_i = '0; bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0;
        bus.mem_rdata_i = '0; bus.fifo_full_i = 0; bus.fifo_pop_i = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        // Streaming to full, single credit return, push+pop at occ=3, then stop.
        vecs[0]  = mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 32'h000, 0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h100, 0, 1);
        vecs[2]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 32'h104, 1, 1);
        vecs[3]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 32'h108, 1, 1);
        vecs[4]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 32'h10C, 1, 1);
        vecs[5]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 32'h110, 1, 1);
        vecs[6]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h110, 0, 1);
        vecs[7]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 32'h110, 0, 1);
        vecs[8]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h110, 0, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h114, 0, 1);
        vecs[10] = mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h114, 1, 1);
        vecs[11] = mk(0, 0, 0, 0, 0, 1, 1, 0, 32'h114, 0, 1);
        vecs[12] = mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h114, 0, 1);
        vecs[13] = mk(0, 0, 0, 0, 1, 0, 1, 0, 32'h118, 1, 1);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h118, 0, 1);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h118, 0, 1);
        vecs[16] = mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h118, 0, 1);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h11C, 0, 1);
        vecs[18] = mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h11C, 1, 1);
        vecs[19] = mk(0, 0, 1, 0, 0, 0, 0, 0, 32'h11C, 0, 1);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h11C, 0, 0);

        idle();
        rst_i = 1'b1;
        #1;
        chk("reset_req",  32'(bus.mem_req_o),   32'd0);
        chk("reset_addr", bus.mem_addr_o,        32'd0);
        chk("reset_push", 32'(bus.fifo_push_o), 32'd0);
        chk("reset_busy", 32'(bus.busy_o),      32'd0);
        chk("reset_ovf",  32'(bus.overflow_o),  32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < NV; i++) begin
            bus.start_i      = vecs[i].start;
            bus.base_addr_i  = vecs[i].base;
            bus.stop_i       = vecs[i].stop;
            bus.mem_gnt_i    = vecs[i].gnt;
            bus.mem_rvalid_i = vecs[i].rvalid;
            bus.mem_rdata_i  = 32'hD000_0000 | 32'(i);
            bus.fifo_full_i  = vecs[i].full;
            bus.fifo_pop_i   = vecs[i].pop;
            #1;
            $display("vec %0d: req=%0b addr=%08h push=%0b data=%08h busy=%0b", i,
                     bus.mem_req_o, bus.mem_addr_o, bus.fifo_push_o, bus.fifo_data_o, bus.busy_o);
            chk($sformatf("v%0d_req", i),  32'(bus.mem_req_o),   32'(vecs[i].e_req));
            chk($sformatf("v%0d_addr", i), bus.mem_addr_o,        vecs[i].e_addr);
            chk($sformatf("v%0d_push", i), 32'(bus.fifo_push_o), 32'(vecs[i].e_push));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy_o),      32'(vecs[i].e_busy));
            chk($sformatf("v%0d_ovf", i),  32'(bus.overflow_o),  32'd0);
            if (vecs[i].e_push)
                chk($sformatf("v%0d_data", i), bus.fifo_data_o, 32'hD000_0000 | 32'(i));
            @(negedge clk_i);
        end

        // Redirect with two requests in flight: both responses dropped, restart at 0x400.
        do_reset();
        bus.start_i = 1; bus.base_addr_i = 32'h200;
        @(negedge clk_i); idle(); bus.mem_gnt_i = 1;
        #1; chk("rd_req0", 32'(bus.mem_req_o), 32'd1); chk("rd_addr0", bus.mem_addr_o, 32'h200);
        @(negedge clk_i);
        #1; chk("rd_addr1", bus.mem_addr_o, 32'h204);
        @(negedge clk_i); idle(); bus.redirect_i = 1; bus.redirect_addr_i = 32'h400;
        #1; chk("rd_req_cap", 32'(bus.mem_req_o), 32'd0);
        $display("redirect issued to 0x400 with 2 in flight");
        @(negedge clk_i); idle(); bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hBAD0_0001;
        #1; chk("rd_drop0", 32'(bus.fifo_push_o), 32'd0); chk("rd_req_drain", 32'(bus.mem_req_o), 32'd0);
        @(negedge clk_i); bus.mem_rdata_i = 32'hBAD0_0002;
        #1; chk("rd_drop1", 32'(bus.fifo_push_o), 32'd0);
        @(negedge clk_i); idle();
        #1; chk("rd_req_new", 32'(bus.mem_req_o), 32'd1); chk("rd_addr_new", bus.mem_addr_o, 32'h400);
        chk("rd_busy", 32'(bus.busy_o), 32'd1);
        $display("redirect stream resumed at 0x%08h", bus.mem_addr_o);
        @(negedge clk_i);

        // Address wrap, stop with data in flight, sticky overflow, stray response.
        do_reset();
        bus.start_i = 1; bus.base_addr_i = 32'hFFFF_FFFC;
        @(negedge clk_i); idle(); bus.mem_gnt_i = 1;
        #1; chk("wr_addr0", bus.mem_addr_o, 32'hFFFF_FFFC); chk("wr_req0", 32'(bus.mem_req_o), 32'd1);
        @(negedge clk_i); bus.stop_i = 1;
        #1; chk("wr_addr1", bus.mem_addr_o, 32'h0000_0000); chk("wr_req1", 32'(bus.mem_req_o), 32'd1);
        @(negedge clk_i); idle(); bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hE000_0000;
        #1; chk("wr_req_stop", 32'(bus.mem_req_o), 32'd0); chk("wr_push0", 32'(bus.fifo_push_o), 32'd1);
        chk("wr_data0", bus.fifo_data_o, 32'hE000_0000); chk("wr_busy0", 32'(bus.busy_o), 32'd1);
        chk("wr_ovf0", 32'(bus.overflow_o), 32'd0);
        @(negedge clk_i); bus.mem_rdata_i = 32'hE000_0001; bus.fifo_full_i = 1;
        #1; chk("wr_push1", 32'(bus.fifo_push_o), 32'd1); chk("wr_data1", bus.fifo_data_o, 32'hE000_0001);
        @(negedge clk_i); idle();
        #1; chk("wr_req_end", 32'(bus.mem_req_o), 32'd0); chk("wr_busy_end", 32'(bus.busy_o), 32'd0);
        chk("wr_ovf_set", 32'(bus.overflow_o), 32'd1); chk("wr_addr_end", bus.mem_addr_o, 32'h4);
        @(negedge clk_i); bus.mem_rvalid_i = 1;
        #1; chk("wr_stray_push", 32'(bus.fifo_push_o), 32'd0);
        @(negedge clk_i); idle();
        #1; chk("wr_ovf_sticky", 32'(bus.overflow_o), 32'd1);
        $display("wrap/stop sequence done, overflow=%0b", bus.overflow_o);

        // Asynchronous reset mid-stream.
        do_reset();
        bus.start_i = 1; bus.base_addr_i = 32'h300;
        @(negedge clk_i); idle(); bus.mem_gnt_i = 1;
        @(negedge clk_i);
        @(negedge clk_i); idle(); bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hC0DE_0000;
        #1; chk("ar_push_before", 32'(bus.fifo_push_o), 32'd1);
        rst_i = 1'b1;
        #1; chk("ar_req", 32'(bus.mem_req_o), 32'd0); chk("ar_push", 32'(bus.fifo_push_o), 32'd0);
        chk("ar_busy", 32'(bus.busy_o), 32'd0); chk("ar_addr", bus.mem_addr_o, 32'd0);
        @(negedge clk_i); rst_i = 1'b0; bus.mem_rvalid_i = 1;
        #1; chk("ar_late_push", 32'(bus.fifo_push_o), 32'd0); chk("ar_late_busy", 32'(bus.busy_o), 32'd0);
        @(negedge clk_i); idle();
        #1; chk("ar_idle_req", 32'(bus.mem_req_o), 32'd0); chk("ar_idle_busy", 32'(bus.busy_o), 32'd0);
        $display("async reset sequence done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
